rca_seq_sched: RTL and testbench

Sequencer and arbiter that shares a single 4-bit ripple-carry adder (`RCA`) between two requesters and uses it iteratively to add WIDTH-bit operands. A winning request is latched and fed through the RCA one 4-bit slice per cycle, least-significant slice first, with the slice carry registered between cycles. The WIDTH+1-bit result is returned on a valid/ready response port tagged with the requester ID. The block sits between operand producers and the shared adder datapath and is the only master of that RCA instance.

---
 rtl/rca_seq_pkg.sv | 16 +
 rtl/rca_seq_sched_rca.sv | 20 ++
 rtl/rca_seq_sched.sv | 113 +++++++++++
 tb/tb_rca_seq_sched.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rca_seq_pkg.sv
// Shared types and helpers for the sequential ripple-carry adder scheduler.
package rca_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam int SLICE_W = 4;

    function automatic int nslice(input int width);
        return width / SLICE_W;
    endfunction

endpackage

// File: rtl/rca_seq_sched_rca.sv
// 4-bit ripple-carry adder; sum[4] is the carry out.
module RCA (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [4:0] sum
);

    always_comb begin
        logic c;
        c   = cin;
        sum = '0;
        for (int i = 0; i < 4; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        sum[4] = c;
    end

endmodule

// File: rtl/rca_seq_sched.sv
// Two-requester round-robin front end that feeds WIDTH-bit additions through
// one shared 4-bit RCA, one slice per cycle, least-significant slice first.
module rca_seq_sched
    import rca_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_cin,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_cin,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH:0]   rsp_sum,
    output logic             rsp_id
);

    localparam int NSLICE = nslice(WIDTH);
    localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(NSLICE - 1);

    state_t             state;
    state_t             next_state;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic               carry_reg;
    logic               last_grant;
    logic               grant;
    logic               accept;
    logic [CNT_W-1:0]   slice_cnt;
    logic [SLICE_W-1:0] slice_a;
    logic [SLICE_W-1:0] slice_b;
    logic [SLICE_W:0]   slice_sum;

    // On a tie the requester that did not win last time is favoured.
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = ~last_grant;
        end else begin
            grant = req1_valid;
        end
    end

    assign req0_ready = (state == IDLE) && !grant;
    assign req1_ready = (state == IDLE) && grant;
    assign accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);
    assign rsp_valid  = (state == DONE);

    assign slice_a = op_a[int'(slice_cnt)*SLICE_W +: SLICE_W];
    assign slice_b = op_b[int'(slice_cnt)*SLICE_W +: SLICE_W];

    RCA u_rca (
        .a   (slice_a),
        .b   (slice_b),
        .cin (carry_reg),
        .sum (slice_sum)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = RUN;
            RUN:     if (slice_cnt == LAST_SLICE) next_state = DONE;
            DONE:    if (rsp_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Operand capture on accept, then one slice of the sum per RUN cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a       <= '0;
            op_b       <= '0;
            carry_reg  <= 1'b0;
            slice_cnt  <= '0;
            last_grant <= 1'b1;
            rsp_id     <= 1'b0;
            rsp_sum    <= '0;
        end else if (state == IDLE && accept) begin
            op_a       <= grant ? req1_a : req0_a;
            op_b       <= grant ? req1_b : req0_b;
            carry_reg  <= grant ? req1_cin : req0_cin;
            slice_cnt  <= '0;
            last_grant <= grant;
            rsp_id     <= grant;
        end else if (state == RUN) begin
            rsp_sum[int'(slice_cnt)*SLICE_W +: SLICE_W] <= slice_sum[SLICE_W-1:0];
            carry_reg <= slice_sum[SLICE_W];
            slice_cnt <= slice_cnt + CNT_W'(1);
            if (slice_cnt == LAST_SLICE) begin
                rsp_sum[WIDTH] <= slice_sum[SLICE_W];
            end
        end
    end

endmodule

// File: tb/tb_rca_seq_sched.sv
// Scoreboard bench for rca_seq_sched: directed scenarios plus a random phase.
module tb_rca_seq_sched;

    localparam int WIDTH = 16;

    typedef struct packed {
        logic           id;
        logic [WIDTH:0] sum;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             req0_valid = 1'b0;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a = '0;
    logic [WIDTH-1:0] req0_b = '0;
    logic             req0_cin = 1'b0;
    logic             req1_valid = 1'b0;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a = '0;
    logic [WIDTH-1:0] req1_b = '0;
    logic             req1_cin = 1'b0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [WIDTH:0]   rsp_sum;
    logic             rsp_id;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    rca_seq_sched #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_cin   (req0_cin),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_cin   (req1_cin),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_sum    (rsp_sum),
        .rsp_id     (rsp_id)
    );

    function automatic logic [WIDTH:0] model_sum(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b,
                                                 input logic cin);
        return {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    endfunction

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        rsp_ready = 1'b0;
        #1;
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_rsp_valid got=%b want=0", rsp_valid); end
        total++; if (rsp_sum !== '0) begin bad++; $display("[TB] FAIL reset_rsp_sum got=%h want=0", rsp_sum); end
        total++; if (rsp_id !== 1'b0) begin bad++; $display("[TB] FAIL reset_rsp_id got=%b want=0", rsp_id); end
        total++; if (req0_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_req0_ready got=%b want=1", req0_ready); end
        total++; if (req1_ready !== 1'b0) begin bad++; $display("[TB] FAIL reset_req1_ready got=%b want=0", req1_ready); end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick;
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_single_op(input string name, input logic [WIDTH-1:0] a,
                                  input logic [WIDTH-1:0] b, input logic cin,
                                  input logic [WIDTH:0] want);
        exp_t e;
        req0_a = a;
        req0_b = b;
        req0_cin = cin;
        req0_valid = 1'b1;
        rsp_ready = 1'b1;
        #1;
        total++; if (req0_ready !== 1'b1) begin bad++; $display("[TB] FAIL %s_accept got=%b want=1", name, req0_ready); end
        if (req0_valid && req0_ready) sb.push_back('{id: 1'b0, sum: want});
        tick;
        req0_valid = 1'b0;
        for (int n = 0; n <= 4; n++) begin
            #1;
            total++; if (rsp_valid !== (n == 4)) begin bad++; $display("[TB] FAIL %s_latency cycle=%0d got=%b want=%b", name, n, rsp_valid, (n == 4)); end
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    total++; bad++; $display("[TB] FAIL %s_unexpected_rsp got=%h want=none", name, rsp_sum);
                end else begin
                    e = sb.pop_front();
                    total++; if (rsp_sum !== e.sum) begin bad++; $display("[TB] FAIL %s_sum got=%h want=%h", name, rsp_sum, e.sum); end
                    total++; if (rsp_id !== e.id) begin bad++; $display("[TB] FAIL %s_id got=%b want=%b", name, rsp_id, e.id); end
                end
            end
            tick;
        end
        total++; if (sb.size() != 0) begin bad++; $display("[TB] FAIL %s_missing_rsp got=%0d pending want=0", name, sb.size()); end
        sb.delete();
    endtask

    task automatic test_tie;
        exp_t e;
        int   got1;
        bit   done;
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        req0_a = 16'h0001; req0_b = 16'h0001; req0_cin = 1'b0;
        req1_a = 16'h8000; req1_b = 16'h8000; req1_cin = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        rsp_ready = 1'b1;
        #1;
        total++; if (req0_ready !== 1'b1) begin bad++; $display("[TB] FAIL tie_req0_ready got=%b want=1", req0_ready); end
        total++; if (req1_ready !== 1'b0) begin bad++; $display("[TB] FAIL tie_req1_ready got=%b want=0", req1_ready); end
        if (req0_valid && req0_ready) sb.push_back('{id: 1'b0, sum: 17'h00002});
        tick;
        req0_valid = 1'b0;
        got1 = -1;
        for (int n = 0; n < 10; n++) begin
            #1;
            if (rsp_valid && rsp_ready) begin
                e = sb.pop_front();
                total++; if (rsp_sum !== e.sum) begin bad++; $display("[TB] FAIL tie_first_sum got=%h want=%h", rsp_sum, e.sum); end
                total++; if (rsp_id !== e.id) begin bad++; $display("[TB] FAIL tie_first_id got=%b want=%b", rsp_id, e.id); end
            end
            if (req1_ready) begin
                got1 = n;
                sb.push_back('{id: 1'b1, sum: 17'h10000});
                tick;
                break;
            end
            tick;
        end
        total++; if (got1 != 5) begin bad++; $display("[TB] FAIL tie_req1_accept_cycle got=%0d want=5", got1); end
        req1_valid = 1'b0;
        done = 1'b0;
        for (int n = 0; n < 10 && !done; n++) begin
            #1;
            if (rsp_valid && rsp_ready && sb.size() != 0) begin
                e = sb.pop_front();
                total++; if (rsp_sum !== e.sum) begin bad++; $display("[TB] FAIL tie_second_sum got=%h want=%h", rsp_sum, e.sum); end
                total++; if (rsp_id !== e.id) begin bad++; $display("[TB] FAIL tie_second_id got=%b want=%b", rsp_id, e.id); end
                done = 1'b1;
            end
            tick;
        end
        total++; if (!done) begin bad++; $display("[TB] FAIL tie_second_timeout got=none want=rsp"); end
        sb.delete();
    endtask

    task automatic test_backpressure;
        exp_t e;
        bit   seen;
        bit   done;
        req0_a = 16'h0F0F; req0_b = 16'h00F1; req0_cin = 1'b1;
        req0_valid = 1'b1;
        rsp_ready = 1'b0;
        #1;
        if (req0_valid && req0_ready) sb.push_back('{id: 1'b0, sum: 17'h01001});
        tick;
        req0_valid = 1'b0;
        req1_a = 16'h1111; req1_b = 16'h2222; req1_cin = 1'b0;
        req1_valid = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 10; n++) begin
            #1;
            if (rsp_valid) begin seen = 1'b1; break; end
            tick;
        end
        total++; if (!seen || sb.size() == 0) begin bad++; $display("[TB] FAIL bp_rsp_timeout got=%b want=1", seen); end
        for (int c = 0; c < 5 && sb.size() != 0; c++) begin
            total++; if (rsp_valid !== 1'b1) begin bad++; $display("[TB] FAIL bp_valid_hold cycle=%0d got=%b want=1", c, rsp_valid); end
            total++; if (rsp_sum !== sb[0].sum) begin bad++; $display("[TB] FAIL bp_sum_hold cycle=%0d got=%h want=%h", c, rsp_sum, sb[0].sum); end
            total++; if (rsp_id !== sb[0].id) begin bad++; $display("[TB] FAIL bp_id_hold cycle=%0d got=%b want=%b", c, rsp_id, sb[0].id); end
            total++; if ({req0_ready, req1_ready} !== 2'b00) begin bad++; $display("[TB] FAIL bp_readys cycle=%0d got=%b want=00", c, {req0_ready, req1_ready}); end
            tick;
            #1;
        end
        rsp_ready = 1'b1;
        #1;
        if (rsp_valid && rsp_ready && sb.size() != 0) begin
            e = sb.pop_front();
            total++; if (rsp_sum !== e.sum) begin bad++; $display("[TB] FAIL bp_sum got=%h want=%h", rsp_sum, e.sum); end
            total++; if (rsp_id !== e.id) begin bad++; $display("[TB] FAIL bp_id got=%b want=%b", rsp_id, e.id); end
        end
        tick;
        #1;
        total++; if (req1_ready !== 1'b1) begin bad++; $display("[TB] FAIL bp_next_accept got=%b want=1", req1_ready); end
        if (req1_valid && req1_ready) sb.push_back('{id: 1'b1, sum: 17'h03333});
        tick;
        req1_valid = 1'b0;
        done = 1'b0;
        for (int n = 0; n < 10 && !done; n++) begin
            #1;
            if (rsp_valid && rsp_ready && sb.size() != 0) begin
                e = sb.pop_front();
                total++; if (rsp_sum !== e.sum) begin bad++; $display("[TB] FAIL bp_next_sum got=%h want=%h", rsp_sum, e.sum); end
                total++; if (rsp_id !== e.id) begin bad++; $display("[TB] FAIL bp_next_id got=%b want=%b", rsp_id, e.id); end
                done = 1'b1;
            end
            tick;
        end
        total++; if (!done) begin bad++; $display("[TB] FAIL bp_next_timeout got=none want=rsp"); end
        sb.delete();
    endtask

    task automatic test_reset_mid_run;
        exp_t e;
        bit   done;
        req0_a = 16'hAAAA; req0_b = 16'h5555; req0_cin = 1'b0;
        req0_valid = 1'b1;
        rsp_ready = 1'b1;
        #1;
        total++; if (req0_ready !== 1'b1) begin bad++; $display("[TB] FAIL rst_run_accept got=%b want=1", req0_ready); end
        tick;
        req0_valid = 1'b0;
        tick;
        tick;
        req1_a = 16'h00FF; req1_b = 16'h0001; req1_cin = 1'b0;
        req1_valid = 1'b1;
        rst_n = 1'b0;
        #1;
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_run_valid got=%b want=0", rsp_valid); end
        total++; if (rsp_sum !== '0) begin bad++; $display("[TB] FAIL rst_run_sum got=%h want=0", rsp_sum); end
        total++; if ({req0_ready, req1_ready} !== 2'b01) begin bad++; $display("[TB] FAIL rst_run_readys got=%b want=01", {req0_ready, req1_ready}); end
        sb.delete();
        tick;
        rst_n = 1'b1;
        #1;
        if (req1_valid && req1_ready) sb.push_back('{id: 1'b1, sum: 17'h00100});
        tick;
        req1_valid = 1'b0;
        done = 1'b0;
        for (int n = 0; n < 10 && !done; n++) begin
            #1;
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    total++; bad++; $display("[TB] FAIL rst_run_unexpected got=%h want=none", rsp_sum);
                end else begin
                    e = sb.pop_front();
                    total++; if (rsp_sum !== e.sum) begin bad++; $display("[TB] FAIL rst_run_after_sum got=%h want=%h", rsp_sum, e.sum); end
                    total++; if (rsp_id !== e.id) begin bad++; $display("[TB] FAIL rst_run_after_id got=%b want=%b", rsp_id, e.id); end
                end
                done = 1'b1;
            end
            tick;
        end
        total++; if (!done) begin bad++; $display("[TB] FAIL rst_run_after_timeout got=none want=rsp"); end
        sb.delete();
    endtask

    task automatic test_random;
        exp_t e;
        logic model_last;
        int   nresp;
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        model_last = 1'b1;
        nresp = 0;
        for (int cyc = 0; cyc < 3000 && nresp < 160; cyc++) begin
            req0_valid = ($urandom_range(0, 99) < 60);
            req1_valid = ($urandom_range(0, 99) < 60);
            req0_a = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
            req0_b = 16'($urandom);
            req0_cin = 1'($urandom);
            req1_a = 16'($urandom);
            req1_b = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
            req1_cin = 1'($urandom);
            rsp_ready = ($urandom_range(0, 99) < 70);
            #1;
            if (rsp_valid) begin
                total++; if ({req0_ready, req1_ready} !== 2'b00) begin bad++; $display("[TB] FAIL rand_ready_in_done got=%b want=00", {req0_ready, req1_ready}); end
            end
            if (req0_valid && req1_valid && (req0_ready || req1_ready)) begin
                total++; if (req1_ready !== ~model_last) begin bad++; $display("[TB] FAIL rand_round_robin got=%b want=%b", req1_ready, ~model_last); end
            end
            if (req0_valid && req0_ready) begin
                sb.push_back('{id: 1'b0, sum: model_sum(req0_a, req0_b, req0_cin)});
                model_last = 1'b0;
            end
            if (req1_valid && req1_ready) begin
                sb.push_back('{id: 1'b1, sum: model_sum(req1_a, req1_b, req1_cin)});
                model_last = 1'b1;
            end
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    total++; bad++; $display("[TB] FAIL rand_unexpected got=%h want=none", rsp_sum);
                end else begin
                    e = sb.pop_front();
                    nresp++;
                    total++; if (rsp_sum !== e.sum) begin bad++; $display("[TB] FAIL rand_sum got=%h want=%h", rsp_sum, e.sum); end
                    total++; if (rsp_id !== e.id) begin bad++; $display("[TB] FAIL rand_id got=%b want=%b", rsp_id, e.id); end
                end
            end
            tick;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready = 1'b1;
        for (int n = 0; n < 20 && sb.size() != 0; n++) begin
            #1;
            if (rsp_valid && rsp_ready) begin
                e = sb.pop_front();
                nresp++;
                total++; if (rsp_sum !== e.sum) begin bad++; $display("[TB] FAIL rand_drain_sum got=%h want=%h", rsp_sum, e.sum); end
                total++; if (rsp_id !== e.id) begin bad++; $display("[TB] FAIL rand_drain_id got=%b want=%b", rsp_id, e.id); end
            end
            tick;
        end
        total++; if (sb.size() != 0) begin bad++; $display("[TB] FAIL rand_pending got=%0d want=0", sb.size()); end
        total++; if (nresp < 150) begin bad++; $display("[TB] FAIL rand_count got=%0d want>=150", nresp); end
        sb.delete();
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset;
        test_single_op("single", 16'h1234, 16'h4321, 1'b0, 17'h05555);
        test_single_op("ripple", 16'hFFFF, 16'h0000, 1'b1, 17'h10000);
        test_single_op("max", 16'hFFFF, 16'hFFFF, 1'b1, 17'h1FFFF);
        test_tie;
        test_backpressure;
        test_reset_mid_run;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
